reg_pipe: RTL and testbench
===========================

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per beat (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset or clear.
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of all stages.
REQ-007 SHALL have port in_valid  input  1  upstream beat present.
REQ-008 SHALL have port in_data  input  WIDTH  upstream beat.
REQ-009 SHALL have port in_ready  output  1  pipe accepts a beat this cycle.
REQ-010 SHALL have port out_valid  output  1  last stage holds a beat.
REQ-011 SHALL have port out_data  output  WIDTH  last-stage data.
REQ-012 SHALL have port out_ready  input  1  downstream accepts a beat this cycle.
REQ-013 SHALL have port occ  output  $clog2(DEPTH+1)  count of valid stages (only with REG_PIPE_OCC_EN).

Function
REQ-014 SHALL hold per stage i (0 = input side, DEPTH-1 = output side) a valid bit v[i] and data d[i].
REQ-015 SHALL compute stage ready as rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready and rdy[i] = ~v[i] | rdy[i+1], i.e. bubbles collapse; in_ready = rdy[0] & reset_n & ~clear.
REQ-016 SHALL, at each posedge where rdy[i], load v[i] from the upstream valid (in_valid for i=0, v[i-1] otherwise); d[i] loads upstream data only when the upstream valid is 1, else d[i] holds.
REQ-017 SHALL hold v[i] and d[i] unchanged when rdy[i] = 0.
REQ-018 SHALL drive out_valid = v[DEPTH-1] and out_data = d[DEPTH-1] directly from registers.
REQ-019 SHALL deliver a beat accepted at edge t on out_valid after edge t+DEPTH-1 (DEPTH cycles) when out_ready stays 1.
REQ-020 SHALL sustain one beat per cycle when out_ready = 1 continuously, including when all stages are full.
REQ-021 SHALL deassert in_ready when all stages are valid and out_ready = 0.
REQ-022 SHALL preserve beat order; no beat is duplicated or dropped except by clear or reset.
REQ-023 SHALL, on clear = 1 at a posedge, set all v[i] = 0 and d[i] = RESET_VAL; the in_data beat of that cycle is not accepted and out_ready of that cycle has no effect.
REQ-024 SHALL document the combinational path out_ready -> in_ready (DEPTH gates long); no other input-to-output combinational path exists.

Reset
REQ-025 SHALL, at a posedge with reset_n = 0, set all v[i] = 0, d[i] = RESET_VAL, occ = 0; hence out_valid = 0, out_data = RESET_VAL.
REQ-026 SHALL force in_ready = 0 while reset_n = 0; reset has priority over clear and over any handshake, including mid-stream.
REQ-027 SHALL present in_ready = 1 in the first cycle after reset_n returns high.

Configuration
REQ-028 SHALL, when macro REG_PIPE_OCC_EN is defined, include port occ and a registered counter: +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither, 0 on reset/clear; occ always equals the number of set v[i].
REQ-029 SHALL, when REG_PIPE_OCC_EN is undefined, omit port occ and the counter; all other behaviour identical.

Structure
REQ-030 SHALL place default WIDTH/DEPTH constants and the occ width function (clog2(DEPTH+1)) in shared package reg_pipe_pkg.
REQ-031 SHALL instantiate DEPTH copies of sub-module reg_pipe_stage (one v/d pair, inputs up_valid, up_data, rdy, clear, reset_n) via a generate loop.
REQ-032 SHALL flag out-of-range parameters (WIDTH<1, DEPTH<1) with an elaboration-time error.

Verification
REQ-033 SHALL cover: WIDTH=8, DEPTH=3, out_ready=1, in_data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on out_valid 3 cycles after each accept.
REQ-034 SHALL cover: DEPTH=3, out_ready=0, push 4 beats -> first 3 accepted, in_ready=0 on 4th, occ=3; raise out_ready -> 4th accepted same cycle, order preserved.
REQ-035 SHALL cover: bubble collapse -- beat in stage 2 stalled, stages 0-1 empty, out_ready=0, in_valid=1 -> in_ready=1, beat advances to stage 1 and stalls behind.
REQ-036 SHALL cover: clear asserted with 2 valid stages and in_valid=1 -> next cycle out_valid=0, occ=0, out_data=RESET_VAL, cleared beats never appear.
REQ-037 SHALL cover: reset_n=0 mid-stream with pipe full -> in_ready=0 during reset, after release out_valid=0, in_ready=1, occ=0.
REQ-038 SHALL cover: random in_valid/out_ready over 10000 cycles, DEPTH=1 and DEPTH=4 -> scoreboard match, occ equals popcount(v) every cycle.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Shared defaults and helpers for the reg_pipe register pipeline.
package reg_pipe_pkg;

    localparam int REG_PIPE_WIDTH = 8;
    localparam int REG_PIPE_DEPTH = 2;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid/data register of reg_pipe; loads on rdy, data only moves with a valid beat.
module reg_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             rdy,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (rdy) begin
            valid <= up_valid;
            // Holding data across bubbles avoids toggling the wide register for nothing.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with collapsing bubbles; latency DEPTH cycles.
// Optional occupancy port/counter is built only when REG_PIPE_OCC_EN is defined.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = REG_PIPE_WIDTH,
    parameter int               DEPTH     = REG_PIPE_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_data,
    input  logic                            out_ready
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0]     occ
`endif
);

    if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
        $error("reg_pipe: WIDTH and DEPTH must both be >= 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        // Stage i can move unless it and every stage after it is full and the sink stalls.
        // This is the only input-to-output combinational path: out_ready -> in_ready,
        // an AND-reduction over the valid bits that grows with DEPTH.
        assign rdy[i] = out_ready | ~(&v[DEPTH-1:i]);

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = v[i-1];
            assign up_data  = d[i-1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear    (clear),
            .rdy      (rdy[i]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign in_ready  = rdy[0] & reset_n & ~clear;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = v[DEPTH-1] & out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            occ <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ <= occ + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ <= occ - OCC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Directed and randomised checks of reg_pipe at DEPTH 3 (RESET_VAL 0x5A), 1 and 4.
module tb_reg_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, clear;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;

    logic       r_in_valid [2];
    logic       r_in_ready [2];
    logic       r_out_valid[2];
    logic       r_out_ready[2];
    logic [7:0] r_in_data  [2];
    logic [7:0] r_out_data [2];

`ifdef REG_PIPE_OCC_EN
    logic [1:0] occ3;
    logic [0:0] occ1;
    logic [2:0] occ4;
`endif

    reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) u_d3 (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef REG_PIPE_OCC_EN
        , .occ(occ3)
`endif
    );

    reg_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .clear(1'b0),
        .in_valid(r_in_valid[0]), .in_data(r_in_data[0]), .in_ready(r_in_ready[0]),
        .out_valid(r_out_valid[0]), .out_data(r_out_data[0]), .out_ready(r_out_ready[0])
`ifdef REG_PIPE_OCC_EN
        , .occ(occ1)
`endif
    );

    reg_pipe #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .reset_n(reset_n), .clear(1'b0),
        .in_valid(r_in_valid[1]), .in_data(r_in_data[1]), .in_ready(r_in_ready[1]),
        .out_valid(r_out_valid[1]), .out_data(r_out_data[1]), .out_ready(r_out_ready[1])
`ifdef REG_PIPE_OCC_EN
        , .occ(occ4)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus/expectation table for the streaming case (DEPTH 3, sink always ready).
    bit         a_iv [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [7:0] a_id [7] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    bit         a_ov [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic [7:0] a_od [7] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

    logic [7:0] sb [2][$];
    int         dep[2] = '{1, 4};

    initial begin
        int  seen;
        logic exp_rdy;

        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            r_in_valid[j]  = 1'b0;
            r_in_data[j]   = 8'h00;
            r_out_ready[j] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("RST_in_ready", in_ready, 0);
        chk("RST_out_valid", out_valid, 0);
        chk("RST_out_data", out_data, 8'h5A);
        chk("RST_d1_out_valid", r_out_valid[0], 0);
        chk("RST_d4_out_data", r_out_data[1], 8'h00);
`ifdef REG_PIPE_OCC_EN
        chk("RST_occ", occ3, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("RST_release_in_ready", in_ready, 1);

        // Streaming: three beats back to back, each out three cycles later
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            in_valid = a_iv[k];
            in_data  = a_id[k];
            #1;
            chk("A_out_valid", out_valid, a_ov[k]);
            if (a_ov[k]) chk("A_out_data", out_data, a_od[k]);
            if (a_iv[k]) chk("A_in_ready", in_ready, 1);
        end

        // Backpressure: fill, fourth beat refused, then accepted when sink frees
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'hA1 + k);
            #1;
            chk("B_in_ready", in_ready, (k < 3) ? 1 : 0);
        end
`ifdef REG_PIPE_OCC_EN
        chk("B_occ_full", occ3, 3);
`endif
        out_ready = 1'b1;
        #1;
        chk("B_in_ready_same_cycle", in_ready, 1);
        chk("B_out_data_0", out_data, 8'hA1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("B_out_valid", out_valid, 1);
            chk("B_out_data", out_data, 8'(8'hA1 + k));
`ifdef REG_PIPE_OCC_EN
            if (k == 1) chk("B_occ_after_both", occ3, 3);
`endif
        end
        @(negedge clk);
        #1;
        chk("B_drained", out_valid, 0);

        // Bubble collapse behind a stalled head beat
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hC1;
        #1;
        chk("C_in_ready_first", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("C_head_valid", out_valid, 1);
        chk("C_head_data", out_data, 8'hC1);
        in_valid = 1'b1;
        in_data  = 8'hC2;
        #1;
        chk("C_bubble_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
`ifdef REG_PIPE_OCC_EN
        chk("C_occ_two", occ3, 2);
`endif
        in_valid = 1'b1;
        in_data  = 8'hC3;
        #1;
        chk("C_stage0_free", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("C_full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("C_out_0", out_data, 8'hC1);
        @(negedge clk);
        #1;
        chk("C_out_1", out_data, 8'hC2);
        @(negedge clk);
        #1;
        chk("C_out_2", out_data, 8'hC3);
        @(negedge clk);
        #1;
        chk("C_drained", out_valid, 0);

        // Clear with two beats inside and a new beat offered
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hD1;
        @(negedge clk);
        in_data  = 8'hD2;
        @(negedge clk);
        clear    = 1'b1;
        in_data  = 8'hD3;
        #1;
        chk("D_in_ready_clear", in_ready, 0);
`ifdef REG_PIPE_OCC_EN
        chk("D_occ_before", occ3, 2);
`endif
        @(negedge clk);
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("D_out_valid", out_valid, 0);
        chk("D_out_data", out_data, 8'h5A);
`ifdef REG_PIPE_OCC_EN
        chk("D_occ", occ3, 0);
`endif
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("D_no_ghost", seen, 0);

        // Reset while full and a handshake is pending
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'hE1 + k);
        end
        @(negedge clk);
        reset_n   = 1'b0;
        in_data   = 8'hE4;
        out_ready = 1'b1;
        #1;
        chk("E_in_ready_in_reset", in_ready, 0);
        @(negedge clk);
        #1;
        chk("E_in_ready_held", in_ready, 0);
        chk("E_out_valid", out_valid, 0);
        chk("E_out_data", out_data, 8'h5A);
        @(negedge clk);
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("E_release_in_ready", in_ready, 1);
        chk("E_release_out_valid", out_valid, 0);
`ifdef REG_PIPE_OCC_EN
        chk("E_occ", occ3, 0);
`endif

        // Random traffic on DEPTH 1 and DEPTH 4 against a queue scoreboard, then drain
        for (int cyc = 0; cyc < 10008; cyc++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (cyc < 10000) begin
                    r_in_valid[j]  = ($urandom_range(0, 9) < 7);
                    r_in_data[j]   = 8'($urandom);
                    r_out_ready[j] = ($urandom_range(0, 9) < 6);
                end else begin
                    r_in_valid[j]  = 1'b0;
                    r_out_ready[j] = 1'b1;
                end
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                exp_rdy = (sb[j].size() < dep[j]) || r_out_ready[j];
                chk("R_in_ready", r_in_ready[j], exp_rdy);
`ifdef REG_PIPE_OCC_EN
                chk("R_occ", (j == 0) ? 32'(occ1) : 32'(occ4), sb[j].size());
`endif
                if (r_out_valid[j] && r_out_ready[j]) begin
                    if (sb[j].size() == 0) chk("R_spurious_beat", r_out_valid[j], 0);
                    else chk("R_data", r_out_data[j], sb[j].pop_front());
                end
                if (r_in_valid[j] && r_in_ready[j]) sb[j].push_back(r_in_data[j]);
            end
        end
        for (int j = 0; j < 2; j++) begin
            chk("R_drained", sb[j].size(), 0);
            chk("R_idle_out_valid", r_out_valid[j], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
